// File: rtl/cajero_if.sv
// cajero_if: card/keypad front end to ATM controller signal bundle
interface cajero_if #(
    parameter int PIN_DIGITS = 4,
    parameter int MONTO_W    = 32
);
    logic                    tarjeta_recibida;
    logic [4*PIN_DIGITS-1:0] pin;
    logic [3:0]              digito;
    logic                    digito_stb;
    logic                    tipo_trans;
    logic                    tipo_stb;
    logic [MONTO_W-1:0]      monto;
    logic                    monto_stb;
    logic [MONTO_W-1:0]      balance;
    logic                    balance_actualizado;
    logic                    entregar_dinero;
    logic                    fondos_insuficientes;
    logic                    limite_excedido;
    logic                    pin_incorrecto;
    logic                    advertencia;
    logic                    bloqueo;
    logic                    timeout;
    modport master (
        output tarjeta_recibida, pin, digito, digito_stb, tipo_trans, tipo_stb, monto, monto_stb,
        input  balance, balance_actualizado, entregar_dinero, fondos_insuficientes,
               limite_excedido, pin_incorrecto, advertencia, bloqueo, timeout
    );
    modport slave (
        input  tarjeta_recibida, pin, digito, digito_stb, tipo_trans, tipo_stb, monto, monto_stb,
        output balance, balance_actualizado, entregar_dinero, fondos_insuficientes,
               limite_excedido, pin_incorrecto, advertencia, bloqueo, timeout
    );
endinterface

// File: rtl/cajero_param.sv
// cajero_param: parametrised ATM session controller with attempt lockout, session limit and timeout
module cajero_param #(
    parameter int                 PIN_DIGITS    = 4,
    parameter int                 MAX_INTENTOS  = 3,
    parameter int                 MONTO_W       = 32,
    parameter logic [MONTO_W-1:0] BALANCE_INIT  = '0,
    parameter logic [MONTO_W-1:0] LIMITE_RETIRO = MONTO_W'(50000),
    parameter int                 TIMEOUT_CYC   = 64
) (
    input logic     clk,
    input logic     rst_n,
    cajero_if.slave bus
);
    localparam int IW = $clog2(PIN_DIGITS + 1);
    localparam int CW = $clog2(MAX_INTENTOS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [2:0] {S_IDLE, S_PIN, S_TIPO, S_MONTO, S_FIN, S_BLOQ} state_t;
    state_t             state, state_n;
    logic [IW-1:0]      idx, idx_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [TW-1:0]      tmr, tmr_n;
    logic [MONTO_W-1:0] bal, bal_n, sess, sess_n;
    logic [MONTO_W:0]   dep, ses;
    logic               mism, mism_n, tipo, tipo_n;
    logic               upd, upd_n, ent, ent_n, fon, fon_n, lim, lim_n, bad, bad_n, tmo, tmo_n;
    logic               dstb_q, tstb_q, mstb_q;
    logic               d_e, t_e, m_e, any_e, act, card_out, last, mis, to_hit;
    assign d_e      = bus.digito_stb & ~dstb_q;
    assign t_e      = bus.tipo_stb & ~tstb_q;
    assign m_e      = bus.monto_stb & ~mstb_q;
    assign any_e    = d_e | t_e | m_e;
    assign act      = state == S_PIN || state == S_TIPO || state == S_MONTO;
    assign card_out = (act || state == S_FIN) && !bus.tarjeta_recibida;
    assign to_hit   = act && !any_e && tmr == TW'(TIMEOUT_CYC - 1);
    assign last     = idx == IW'(PIN_DIGITS - 1);
    assign mis      = mism | (bus.digito != bus.pin[{idx, 2'b00} +: 4]);
    assign dep      = {1'b0, bal} + {1'b0, bus.monto};
    assign ses      = {1'b0, sess} + {1'b0, bus.monto};
    assign bus.balance              = bal;
    assign bus.balance_actualizado  = upd;
    assign bus.entregar_dinero      = ent;
    assign bus.fondos_insuficientes = fon;
    assign bus.limite_excedido      = lim;
    assign bus.pin_incorrecto       = bad;
    assign bus.timeout              = tmo;
    assign bus.advertencia          = cnt == CW'(MAX_INTENTOS - 1);
    assign bus.bloqueo              = state == S_BLOQ;
    // State and datapath registers; strobe history kept for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            {idx, cnt, tmr, sess} <= '0;
            bal <= BALANCE_INIT;
            {mism, tipo, upd, ent, fon, lim, bad, tmo} <= '0;
            {dstb_q, tstb_q, mstb_q} <= '0;
        end else begin
            state <= state_n;
            {idx, cnt, tmr, sess, bal} <= {idx_n, cnt_n, tmr_n, sess_n, bal_n};
            {mism, tipo, upd, ent, fon, lim, bad, tmo} <= {mism_n, tipo_n, upd_n, ent_n, fon_n, lim_n, bad_n, tmo_n};
            {dstb_q, tstb_q, mstb_q} <= {bus.digito_stb, bus.tipo_stb, bus.monto_stb};
        end
    end
    // Next state: card removal beats timeout, timeout beats nothing since it needs an idle cycle
    always_comb begin
        state_n = state;
        if (card_out) state_n = S_IDLE;
        else if (to_hit) state_n = S_FIN;
        else
            case (state)
                S_IDLE:  state_n = bus.tarjeta_recibida ? S_PIN : S_IDLE;
                S_PIN:   state_n = !(d_e && last) ? S_PIN : !mis ? S_TIPO :
                                   cnt == CW'(MAX_INTENTOS - 1) ? S_BLOQ : S_PIN;
                S_TIPO:  state_n = t_e ? S_MONTO : S_TIPO;
                S_MONTO: state_n = m_e ? S_TIPO : S_MONTO;
                default: state_n = state;
            endcase
    end
    // Datapath updates and result pulses; rejected requests leave balance and session total alone
    always_comb begin
        idx_n  = idx;
        mism_n = mism;
        cnt_n  = cnt;
        tipo_n = tipo;
        bal_n  = bal;
        sess_n = state == S_IDLE ? '0 : sess;
        tmr_n  = act && !any_e ? tmr + TW'(1) : '0;
        {upd_n, ent_n, fon_n, lim_n, bad_n} = '0;
        tmo_n  = to_hit && !card_out;
        if (state == S_IDLE) begin
            idx_n  = '0;
            mism_n = 1'b0;
        end else if (!card_out) begin
            if (state == S_PIN && d_e) begin
                idx_n  = last ? '0 : idx + IW'(1);
                mism_n = last ? 1'b0 : mis;
                cnt_n  = !last ? cnt : mis ? cnt + CW'(1) : '0;
                bad_n  = last && mis;
            end
            if (state == S_TIPO && t_e) tipo_n = bus.tipo_trans;
            if (state == S_MONTO && m_e) begin
                if (!tipo) begin
                    lim_n = dep[MONTO_W];
                    upd_n = !dep[MONTO_W];
                    bal_n = dep[MONTO_W] ? bal : dep[MONTO_W-1:0];
                end else begin
                    fon_n  = bus.monto > bal;
                    lim_n  = !fon_n && ses > {1'b0, LIMITE_RETIRO};
                    upd_n  = !fon_n && !lim_n;
                    ent_n  = upd_n;
                    bal_n  = upd_n ? bal - bus.monto : bal;
                    sess_n = upd_n ? ses[MONTO_W-1:0] : sess;
                end
            end
        end
    end
endmodule
